// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types for the data-memory arbiter
// Contents: DATA_W bus width, arb_owner_t (who holds the memory port this cycle),
//           mem_req_t (one request port: we/addr/wdata).
package dmem_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } arb_owner_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between CPU, host, arbiter and data memory
// Signals: cpu_* load/store path, host_* loader/debug port, mem_* DATA_MEMORY port.
// Modports: slave  = arbiter view (takes requests, drives memory and responses)
//           master = environment view (CPU, host and memory side)
interface dmem_arbiter_if;

  logic                               cpu_req;
  logic                               cpu_we;
  logic [dmem_arbiter_pkg::DATA_W-1:0] cpu_addr;
  logic [dmem_arbiter_pkg::DATA_W-1:0] cpu_wdata;
  logic [dmem_arbiter_pkg::DATA_W-1:0] cpu_rdata;
  logic                               cpu_stall;

  logic                               host_valid;
  logic                               host_we;
  logic [dmem_arbiter_pkg::DATA_W-1:0] host_addr;
  logic [dmem_arbiter_pkg::DATA_W-1:0] host_wdata;
  logic                               host_ready;
  logic                               host_rvalid;
  logic [dmem_arbiter_pkg::DATA_W-1:0] host_rdata;

  logic [dmem_arbiter_pkg::DATA_W-1:0] mem_addr;
  logic                               mem_we;
  logic [dmem_arbiter_pkg::DATA_W-1:0] mem_wd;
  logic [dmem_arbiter_pkg::DATA_W-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata,
    output mem_addr, mem_we, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata,
    input  mem_addr, mem_we, mem_wd,
    output mem_rd
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// rtl/dmem_arbiter_sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst (async, active-high), clr (clear, wins over inc),
//        inc (count up, sticks at MAX), cnt (current value).
module dmem_arbiter_sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority arbiter for the single data-memory port
// Ports: clk, rst (async, active-high); bus (dmem_arbiter_if.slave: CPU, host
//        and DATA_MEMORY signals); owner (current grant, combinational);
//        stall_cycles (saturating count of CPU stall cycles).
// The CPU wins by default; a waiting host request is forced through after
// HOST_MAX_WAIT consecutive losses, stalling the CPU for that cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int HOST_MAX_WAIT = 4,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_arbiter_if.slave          bus,
  output arb_owner_t             owner,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int                WAIT_W   = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              grant_host;
  logic              grant_cpu;
  mem_req_t          cpu_r;
  mem_req_t          host_r;
  mem_req_t          sel_r;

  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q,  host_rdata_d;

  // Grant: host only when the CPU is idle or the host has waited its limit.
  always_comb begin
    grant_host = bus.host_valid && (!bus.cpu_req || (wait_cnt == WAIT_MAX));
    grant_cpu  = bus.cpu_req && !grant_host;
  end

  always_comb begin
    owner = OWN_NONE;
    if (grant_host) begin
      owner = OWN_HOST;
    end else if (grant_cpu) begin
      owner = OWN_CPU;
    end
  end

  // Memory mux. The write enable is qualified by a grant so an idle or
  // losing requester can never write.
  always_comb begin
    cpu_r  = '{we: bus.cpu_we,  addr: bus.cpu_addr,  wdata: bus.cpu_wdata};
    host_r = '{we: bus.host_we, addr: bus.host_addr, wdata: bus.host_wdata};
    sel_r  = grant_host ? host_r : cpu_r;
  end

  assign bus.mem_addr   = sel_r.addr;
  assign bus.mem_wd     = sel_r.wdata;
  assign bus.mem_we     = sel_r.we && (grant_host || grant_cpu);
  assign bus.cpu_rdata  = bus.mem_rd;
  assign bus.cpu_stall  = bus.cpu_req && grant_host;
  assign bus.host_ready = grant_host;

  // Consecutive cycles the pending host request has lost to the CPU.
  dmem_arbiter_sat_counter #(
    .W   (WAIT_W),
    .MAX (WAIT_MAX)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (grant_host || !bus.host_valid),
    .inc (bus.host_valid && !grant_host),
    .cnt (wait_cnt)
  );

  dmem_arbiter_sat_counter #(
    .W   (STALL_CNT_W),
    .MAX ('1)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (bus.cpu_stall),
    .cnt (stall_cycles)
  );

  // Host read response: memory read is asynchronous, so the data is captured
  // on the accept edge and presented for exactly one cycle afterwards.
  always_comb begin
    host_rvalid_d = grant_host && !bus.host_we;
    host_rdata_d  = host_rdata_q;
    if (host_rvalid_d) begin
      host_rdata_d = bus.mem_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  arb_owner_t  owner;
  logic [15:0] stall_cycles;
  int          vec_cnt;
  int          err_cnt;

  logic [31:0] mem [0:255];

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .HOST_MAX_WAIT (4),
    .STALL_CNT_W   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .owner        (owner),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: synchronous write, asynchronous read, word indexed.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wd;
  end
  assign bus.mem_rd = mem[bus.mem_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = 32'h0;
    bus.cpu_wdata  = 32'h0;
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 32'h0;
    bus.host_wdata = 32'h0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1;
    idle_inputs();

    // Reset then idle
    tick();
    tick();
    check("rst_owner",       32'(owner), 32'(OWN_NONE));
    check("rst_mem_we",      32'(bus.mem_we), 32'd0);
    check("rst_stall_cyc",   32'(stall_cycles), 32'd0);
    check("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    check("rst_host_rdata",  bus.host_rdata, 32'h0);
    rst = 1'b0;
    bus.cpu_we  = 1'b1;
    bus.host_we = 1'b1;
    settle();
    check("idle_owner",      32'(owner), 32'(OWN_NONE));
    check("idle_mem_we",     32'(bus.mem_we), 32'd0);
    check("idle_cpu_stall",  32'(bus.cpu_stall), 32'd0);
    check("idle_host_ready", 32'(bus.host_ready), 32'd0);
    idle_inputs();
    tick();

    // Host only: write then read back
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 32'h10;
    bus.host_wdata = 32'hDEADBEEF;
    settle();
    check("hw_ready",  32'(bus.host_ready), 32'd1);
    check("hw_owner",  32'(owner), 32'(OWN_HOST));
    check("hw_mem_we", 32'(bus.mem_we), 32'd1);
    tick();
    check("hw_no_rvalid", 32'(bus.host_rvalid), 32'd0);
    bus.host_we = 1'b0;
    settle();
    check("hr_ready",  32'(bus.host_ready), 32'd1);
    check("hr_mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    bus.host_valid = 1'b0;
    settle();
    check("hr_rvalid", 32'(bus.host_rvalid), 32'd1);
    check("hr_rdata",  bus.host_rdata, 32'hDEADBEEF);
    tick();
    check("hr_rvalid_pulse", 32'(bus.host_rvalid), 32'd0);
    check("hr_rdata_hold",   bus.host_rdata, 32'hDEADBEEF);

    // CPU only: store then load
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h20;
    bus.cpu_wdata = 32'h12345678;
    settle();
    check("cs_stall",  32'(bus.cpu_stall), 32'd0);
    check("cs_owner",  32'(owner), 32'(OWN_CPU));
    check("cs_mem_we", 32'(bus.mem_we), 32'd1);
    tick();
    bus.cpu_we = 1'b0;
    settle();
    check("cl_stall", 32'(bus.cpu_stall), 32'd0);
    check("cl_rdata", bus.cpu_rdata, 32'h12345678);
    tick();
    idle_inputs();
    settle();

    // Same-address contention with wait_cnt at 0: CPU first, host next
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = 1'b1;
    bus.cpu_addr   = 32'h40;
    bus.cpu_wdata  = 32'hAAAA0000;
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 32'h40;
    bus.host_wdata = 32'h5555FFFF;
    settle();
    check("ct_host_ready0", 32'(bus.host_ready), 32'd0);
    check("ct_owner0",      32'(owner), 32'(OWN_CPU));
    check("ct_stall0",      32'(bus.cpu_stall), 32'd0);
    check("ct_mem_wd0",     bus.mem_wd, 32'hAAAA0000);
    tick();
    check("ct_mem_mid", mem[16], 32'hAAAA0000);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    settle();
    check("ct_host_ready1", 32'(bus.host_ready), 32'd1);
    check("ct_owner1",      32'(owner), 32'(OWN_HOST));
    tick();
    idle_inputs();
    settle();
    check("ct_mem_final",  mem[16], 32'h5555FFFF);
    check("ct_stall_cyc",  32'(stall_cycles), 32'd0);

    // Starvation bound: host forced through every 5th cycle
    bus.cpu_req    = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_addr  = 32'h10;
    for (int c = 1; c <= 20; c++) begin
      settle();
      check($sformatf("sv_ready_c%0d", c), 32'(bus.host_ready), (c % 5 == 0) ? 32'd1 : 32'd0);
      check($sformatf("sv_stall_c%0d", c), 32'(bus.cpu_stall),  (c % 5 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    idle_inputs();
    settle();
    check("sv_stall_cycles", 32'(stall_cycles), 32'd4);
    check("sv_rdata",        bus.host_rdata, 32'hDEADBEEF);
    tick();

    // Reset mid-read: accepted read is dropped
    bus.host_valid = 1'b1;
    bus.host_addr  = 32'h40;
    settle();
    check("rm_ready", 32'(bus.host_ready), 32'd1);
    #2;
    rst = 1'b1;
    settle();
    check("rm_rvalid_async", 32'(bus.host_rvalid), 32'd0);
    tick();
    check("rm_rvalid_edge", 32'(bus.host_rvalid), 32'd0);
    idle_inputs();
    rst = 1'b0;
    tick();
    check("rm_rvalid_after", 32'(bus.host_rvalid), 32'd0);
    check("rm_stall_cyc",    32'(stall_cycles), 32'd0);
    check("rm_rdata",        bus.host_rdata, 32'h0);

    // wait_cnt restarted at 0: host forced through on the 5th contended cycle
    bus.cpu_req    = 1'b1;
    bus.host_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      settle();
      check($sformatf("rw_ready_c%0d", c), 32'(bus.host_ready), (c == 5) ? 32'd1 : 32'd0);
      tick();
    end
    idle_inputs();
    tick();
    check("rw_stall_cyc", 32'(stall_cycles), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port between the CPU load/store path and an external host port (loader or debug DMA) that can read and write data memory while the program runs.
- CPU has priority. A bounded-wait counter guarantees host progress; when the host wins, the CPU is stalled.
- Sits between the CPU datapath (ALU_out / RegRD2 / ReadData) and the DATA_MEMORY instance. The memory has a synchronous write and an asynchronous read.

Parameters:
- HOST_MAX_WAIT, 4, maximum consecutive cycles a valid host request may lose to the CPU before it is forced through (must be ≥1).
- STALL_CNT_W, 16, width of the saturating CPU-stall performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU performs a load or store this cycle
- cpu_we  in  1  CPU store
- cpu_addr  in  32  CPU byte address (DATA_BUS)
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  load data, combinational from mem_rd
- cpu_stall  out  1  CPU must hold PC and suppress RegWrite/MemWrite this cycle
- host_valid  in  1  host request pending
- host_we  in  1  host write
- host_addr  in  32  host byte address
- host_wdata  in  32  host write data
- host_ready  out  1  host request accepted this cycle (combinational)
- host_rvalid  out  1  registered read response valid, one-cycle pulse
- host_rdata  out  32  registered read data
- mem_addr  out  32  to DATA_MEMORY A
- mem_we  out  1  to DATA_MEMORY WE
- mem_wd  out  32  to DATA_MEMORY WD
- mem_rd  in  32  from DATA_MEMORY RD
- owner  out  2  arb_owner_t: OWN_NONE, OWN_CPU, OWN_HOST (combinational)
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with cpu_stall=1

Behaviour:
- Grant logic (combinational):
  - grant_host = host_valid && (!cpu_req || wait_cnt == HOST_MAX_WAIT)
  - grant_cpu = cpu_req && !grant_host
  - host_ready = grant_host
  - cpu_stall = cpu_req && grant_host
- owner: OWN_HOST if grant_host, OWN_CPU if grant_cpu, else OWN_NONE.
- Memory mux:
  - grant_host: mem_addr/mem_wd/mem_we = host_addr/host_wdata/host_we.
  - Otherwise: mem_addr = cpu_addr, mem_wd = cpu_wdata, mem_we = grant_cpu && cpu_we.
  - mem_we is never 1 with owner == OWN_NONE.
- cpu_rdata = mem_rd at all times. It is only meaningful when grant_cpu.
- wait_cnt (width $clog2(HOST_MAX_WAIT+1)):
  - reset 0
  - cleared to 0 when grant_host or !host_valid
  - incremented when host_valid && !grant_host, saturating at HOST_MAX_WAIT
- Host read response:
  - On an accepted read (grant_host && !host_we), host_rdata <= mem_rd and host_rvalid <= 1 on the next edge.
  - host_rvalid is otherwise 0 and is a single-cycle pulse.
  - host_rdata holds its last value when host_rvalid is 0.
- Host writes complete at the accept edge. No response pulse.
- Back-to-back host requests: one per cycle while granted.
- Host hold rule: the host holds all request fields stable while host_valid=1 and host_ready=0. Any change is a host protocol error. Behaviour is not required to be defined in that case.
- Fairness: after a forced host grant, wait_cnt=0, so continuous CPU traffic wins the next HOST_MAX_WAIT cycles. A continuous host stream against a continuous CPU stream yields a pattern of HOST_MAX_WAIT CPU grants then 1 host grant.
- stall_cycles: +1 per cycle with cpu_stall=1, saturating at all ones, never wraps.
- Reset values: wait_cnt=0, host_rvalid=0, host_rdata=0, stall_cycles=0.
  - Combinational outputs follow their inputs.
  - With all requests low: owner=OWN_NONE, mem_we=0, cpu_stall=0, host_ready=0.
- Reset mid-operation: an accepted host read whose response is not yet presented is dropped (host_rvalid stays 0). A write accepted on the same edge as the rst assertion is a memory-side race. The host must retry.
- Same-address same-cycle: only the granted side touches memory. The losing side re-presents next cycle.

Decomposition:
- Add to types_pkg:
  - arb_owner_t enum (OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_HOST=2'd2)
  - mem_req_t struct {we, addr DATA_BUS, wdata DATA_BUS} for both request ports
- No sub-module required.
- Optional: the saturating counter as sat_counter (parameterised width). It is reused for wait_cnt and stall_cycles.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all requests 0 → owner=OWN_NONE, mem_we=0, stall_cycles=0, host_rvalid=0.
- Host only: host write 0xDEADBEEF to 0x10, next cycle host read 0x10 → host_ready=1 both cycles; one cycle after the read, host_rvalid=1 and host_rdata=0xDEADBEEF.
- CPU only: CPU store 0x12345678 to 0x20, then load 0x20 → cpu_stall=0 throughout; cpu_rdata=0x12345678 in the load cycle.
- Starvation bound: cpu_req held 1 for 20 cycles and host_valid held 1 (HOST_MAX_WAIT=4) → host_ready asserts on cycles 5, 10, 15, 20 only; cpu_stall matches; stall_cycles=4 at end.
- Contention on same address: CPU store 0xAAAA0000 and host write 0x5555FFFF to 0x40 in the same cycle with wait_cnt=0 → CPU wins; host accepted the next cycle; final mem[0x40]=0x5555FFFF.
- Reset mid-read: host read accepted, rst asserted before the next edge → host_rvalid never pulses; after release, wait_cnt=0 and stall_cycles=0.
